// File: rtl/ac_layer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ac_layer_ctrl_pkg
// Purpose : shared definitions for the layer controller slice: FSM state
//           encoding, default widths/timeouts and the expected-output helper.
// Contents: AW_DEFAULT, DRAIN_TO_DEFAULT, state_t, expectedCount()
// ---------------------------------------------------------------------------
package ac_layer_ctrl_pkg;

    localparam int AW_DEFAULT       = 16;
    localparam int DRAIN_TO_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With 2x2 max-pooling the core emits one result per four windows.
    function automatic logic [31:0] expectedCount(input logic [31:0] nWin,
                                                  input logic        mp);
        return mp ? (nWin >> 2) : nWin;
    endfunction

endpackage

// File: rtl/ac_out_counter.sv
// ---------------------------------------------------------------------------
// ac_out_counter
// Purpose : tracks how many results the arithmetic core has returned for the
//           current layer, saturating at the expected count, and times out
//           the drain phase.
// Ports   : clk, reset (async, active-low)
//           i_clear     - accepted layer start; latches expected count, clears
//           i_nWin      - window count of the layer being started
//           i_mp        - pooling enable of the layer being started
//           i_countEn   - controller is busy; results are only counted then
//           i_coreOutEn - result strobe from the core
//           i_drain     - controller is in the drain phase
//           o_outCnt    - results received so far
//           o_reached   - o_outCnt has reached the expected count
//           o_timeout   - drain has run DRAIN_TO cycles without completing
// ---------------------------------------------------------------------------
module ac_out_counter
    import ac_layer_ctrl_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DRAIN_TO = DRAIN_TO_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic [AW-1:0] i_nWin,
    input  logic          i_mp,
    input  logic          i_countEn,
    input  logic          i_coreOutEn,
    input  logic          i_drain,
    output logic [AW-1:0] o_outCnt,
    output logic          o_reached,
    output logic          o_timeout
);

    localparam int            TW      = $clog2(DRAIN_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(DRAIN_TO - 1);

    logic [AW-1:0] r_expCnt;
    logic [AW-1:0] r_outCnt;
    logic [TW-1:0] r_drainCyc;

    // Expected count is computed once at start from the raw config inputs,
    // since the controller latches its own copy on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expCnt <= '0;
            r_outCnt <= '0;
        end else if (i_clear) begin
            r_expCnt <= AW'(expectedCount(32'(i_nWin), i_mp));
            r_outCnt <= '0;
        end else if (i_countEn && i_coreOutEn && (r_outCnt < r_expCnt)) begin
            r_outCnt <= r_outCnt + AW'(1);
        end
    end

    // Drain cycle counter restarts every time the drain phase is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drainCyc <= '0;
        end else if (!i_drain) begin
            r_drainCyc <= '0;
        end else if (r_drainCyc != TO_LAST) begin
            r_drainCyc <= r_drainCyc + TW'(1);
        end
    end

    assign o_outCnt  = r_outCnt;
    assign o_reached = (r_outCnt == r_expCnt);
    assign o_timeout = i_drain && !o_reached && (r_drainCyc == TO_LAST);

endmodule

// File: rtl/ac_layer_ctrl.sv
// ---------------------------------------------------------------------------
// ac_layer_ctrl
// Purpose : sequences one convolution layer: issues one window-buffer read
//           per cycle, forwards the latched layer configuration to the
//           arithmetic core, waits for the core's results, then reports done
//           (or a drain timeout).
// Ports   : clk, reset (async, active-low)
//           start, cfg_n_win/bias/bound/step/relu/mp - layer start + config
//           pause                 - holds window issue while high
//           win_rd, win_addr      - window-buffer read request
//           core_en               - core input valid (win_rd one cycle later)
//           core_bias/bound/step/relu/mp - latched config to the core
//           core_out_en           - result strobe from the core
//           busy, done, err_to, out_cnt - status
// ---------------------------------------------------------------------------
module ac_layer_ctrl
    import ac_layer_ctrl_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DRAIN_TO = DRAIN_TO_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] cfg_n_win,
    input  logic [15:0]   cfg_bias,
    input  logic [2:0]    cfg_bound,
    input  logic [2:0]    cfg_step,
    input  logic          cfg_relu,
    input  logic          cfg_mp,
    input  logic          pause,
    output logic          win_rd,
    output logic [AW-1:0] win_addr,
    output logic          core_en,
    output logic [15:0]   core_bias,
    output logic [2:0]    core_bound,
    output logic [2:0]    core_step,
    output logic          core_relu,
    output logic          core_mp,
    input  logic          core_out_en,
    output logic          busy,
    output logic          done,
    output logic          err_to,
    output logic [AW-1:0] out_cnt
);

    state_t        r_state;
    logic [AW-1:0] r_issueIdx;
    logic [AW-1:0] r_nWin;
    logic          r_busy;
    logic          r_done;
    logic          r_errTo;
    logic          r_coreEn;
    logic [15:0]   r_coreBias;
    logic [2:0]    r_coreBound;
    logic [2:0]    r_coreStep;
    logic          r_coreRelu;
    logic          r_coreMp;

    logic          w_startAcc;
    logic          w_winRd;
    logic          w_lastIssue;
    logic          w_reached;
    logic          w_timeout;
    logic [AW-1:0] w_outCnt;

    assign w_startAcc  = (r_state == ST_IDLE) && start;
    // Read request follows pause in the same cycle so a paused cycle never
    // consumes an address.
    assign w_winRd     = (r_state == ST_STREAM) && !pause;
    assign w_lastIssue = (r_issueIdx == (r_nWin - AW'(1)));

    // Layer sequencing: the state register, issue index, latched config and
    // the busy/done/err_to status are all updated together here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_issueIdx  <= '0;
            r_nWin      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_errTo     <= 1'b0;
            r_coreBias  <= '0;
            r_coreBound <= '0;
            r_coreStep  <= '0;
            r_coreRelu  <= 1'b0;
            r_coreMp    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_nWin      <= cfg_n_win;
                        r_issueIdx  <= '0;
                        r_errTo     <= 1'b0;
                        r_coreBias  <= cfg_bias;
                        r_coreBound <= cfg_bound;
                        r_coreStep  <= cfg_step;
                        r_coreRelu  <= cfg_relu;
                        r_coreMp    <= cfg_mp;
                        // An empty layer finishes immediately without reads.
                        if (cfg_n_win == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_STREAM;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (!pause) begin
                        r_issueIdx <= r_issueIdx + AW'(1);
                        if (w_lastIssue) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_reached) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_errTo <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the request, so core_en is the
    // request delayed by one register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_coreEn <= 1'b0;
        end else begin
            r_coreEn <= w_winRd;
        end
    end

    ac_out_counter #(
        .AW       (AW),
        .DRAIN_TO (DRAIN_TO)
    ) u_outCounter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_startAcc),
        .i_nWin      (cfg_n_win),
        .i_mp        (cfg_mp),
        .i_countEn   (r_busy),
        .i_coreOutEn (core_out_en),
        .i_drain     (r_state == ST_DRAIN),
        .o_outCnt    (w_outCnt),
        .o_reached   (w_reached),
        .o_timeout   (w_timeout)
    );

    assign win_rd     = w_winRd;
    assign win_addr   = r_issueIdx;
    assign core_en    = r_coreEn;
    assign core_bias  = r_coreBias;
    assign core_bound = r_coreBound;
    assign core_step  = r_coreStep;
    assign core_relu  = r_coreRelu;
    assign core_mp    = r_coreMp;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_to     = r_errTo;
    assign out_cnt    = w_outCnt;

endmodule

// File: tb/tb_ac_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ac_layer_ctrl
// Purpose : self-checking bench for ac_layer_ctrl. A stimulus process plans
//           each layer (pause pattern, core result timing) from the layer
//           rules, queues the expected reads and the expected completion,
//           and a monitor process compares what the DUT presents.
// ---------------------------------------------------------------------------
module tb_ac_layer_ctrl;

    localparam int AW       = 16;
    localparam int DRAIN_TO = 64;

    typedef struct {
        int addr;
        int cycle;
    } rdExp_t;

    typedef struct {
        int          cycle;
        int          cnt;
        bit          err;
        logic [23:0] cfg;
    } doneExp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] cfg_n_win;
    logic [15:0]   cfg_bias;
    logic [2:0]    cfg_bound;
    logic [2:0]    cfg_step;
    logic          cfg_relu;
    logic          cfg_mp;
    logic          pause;
    logic          win_rd;
    logic [AW-1:0] win_addr;
    logic          core_en;
    logic [15:0]   core_bias;
    logic [2:0]    core_bound;
    logic [2:0]    core_step;
    logic          core_relu;
    logic          core_mp;
    logic          core_out_en;
    logic          busy;
    logic          done;
    logic          err_to;
    logic [AW-1:0] out_cnt;

    int       passCount  = 0;
    int       checkCount = 0;
    int       cyc        = 0;
    bit       monOn      = 0;
    bit       prevWinRd  = 0;
    bit       expBusy    = 0;
    bit       expStream  = 0;
    int       expIdx     = 0;
    rdExp_t   addrQ[$];
    doneExp_t doneQ[$];

    ac_layer_ctrl #(
        .AW       (AW),
        .DRAIN_TO (DRAIN_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_n_win   (cfg_n_win),
        .cfg_bias    (cfg_bias),
        .cfg_bound   (cfg_bound),
        .cfg_step    (cfg_step),
        .cfg_relu    (cfg_relu),
        .cfg_mp      (cfg_mp),
        .pause       (pause),
        .win_rd      (win_rd),
        .win_addr    (win_addr),
        .core_en     (core_en),
        .core_bias   (core_bias),
        .core_bound  (core_bound),
        .core_step   (core_step),
        .core_relu   (core_relu),
        .core_mp     (core_mp),
        .core_out_en (core_out_en),
        .busy        (busy),
        .done        (done),
        .err_to      (err_to),
        .out_cnt     (out_cnt)
    );

    // Free-running clock and a cycle index shared by stimulus and monitor.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge and pops expectations whenever
    // the DUT presents a read or a done pulse.
    always @(negedge clk) begin
        rdExp_t   r;
        doneExp_t d;
        if (!reset) begin
            prevWinRd = 1'b0;
        end else if (monOn) begin
            if (win_rd) begin
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected_read", int'(win_addr), -1);
                end else begin
                    r = addrQ.pop_front();
                    checkOutput("read_addr", int'(win_addr), r.addr);
                    checkOutput("read_cycle", cyc, r.cycle);
                end
            end
            checkOutput("core_en_lag", int'(core_en), int'(prevWinRd));
            prevWinRd = win_rd;
            checkOutput("busy", int'(busy), int'(expBusy));
            if (expStream && pause) begin
                checkOutput("pause_no_read", int'(win_rd), 0);
                checkOutput("pause_addr_hold", int'(win_addr), expIdx);
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_done", int'(done), 0);
                end else begin
                    d = doneQ.pop_front();
                    checkOutput("done_cycle", cyc, d.cycle);
                    checkOutput("done_out_cnt", int'(out_cnt), d.cnt);
                    checkOutput("done_err_to", int'(err_to), int'(d.err));
                    checkOutput("done_core_cfg",
                                int'({core_bias, core_bound, core_step, core_relu, core_mp}),
                                int'(d.cfg));
                end
            end
        end
    end

    // Plans and drives one complete layer. The read schedule follows from
    // the pause pattern (one address per unpaused cycle), result pulses come
    // 'lat' cycles after each of the first k reads, and completion is either
    // the cycle after the expected count is in hand or DRAIN_TO cycles into
    // the drain phase.
    task automatic applyStimulus(input int n, input bit mp, input bit relu,
                                 input logic [15:0] bias, input logic [2:0] bound,
                                 input logic [2:0] step, input int k, input int lat,
                                 input int pausePct, input bit pauseFixed,
                                 input bit secondStart);
        int       readCycles[$];
        bit       pauseSeq[$];
        bit       pulseMap[];
        int       idx, t, c, expN, expCnt, doneRel, lastPulse, endRel, s, ptr, pk;
        bit       err, pz;
        doneExp_t d;
        rdExp_t   r;

        idx = 0;
        t   = 1;
        while (idx < n) begin
            pz = pauseFixed ? (t >= 11 && t <= 15) : ($urandom_range(0, 99) < pausePct);
            pauseSeq.push_back(pz);
            if (!pz) begin
                readCycles.push_back(t);
                idx++;
            end
            t++;
        end
        c         = (n > 0) ? readCycles[n-1] : 0;
        expN      = mp ? n / 4 : n;
        err       = (k < expN);
        expCnt    = err ? k : expN;
        lastPulse = (k > 0) ? readCycles[k-1] + lat : 0;
        if (n == 0) begin
            doneRel = 1;
        end else if (err) begin
            doneRel = c + DRAIN_TO + 1;
        end else if (expN == 0) begin
            doneRel = c + 2;
        end else begin
            pk      = readCycles[expN-1] + lat;
            doneRel = ((pk > c) ? pk : c) + 2;
        end
        endRel   = ((doneRel > lastPulse) ? doneRel : lastPulse) + 2;
        pulseMap = new[endRel + 1];
        for (int j = 0; j < k; j++) pulseMap[readCycles[j] + lat] = 1'b1;

        @(posedge clk); #1;
        s           = cyc;
        start       = 1'b1;
        cfg_n_win   = AW'(n);
        cfg_bias    = bias;
        cfg_bound   = bound;
        cfg_step    = step;
        cfg_relu    = relu;
        cfg_mp      = mp;
        pause       = 1'($urandom_range(0, 1));
        core_out_en = 1'($urandom_range(0, 1));
        expBusy     = 1'b0;
        expStream   = 1'b0;
        for (int j = 0; j < n; j++) begin
            r.addr  = j;
            r.cycle = s + readCycles[j];
            addrQ.push_back(r);
        end
        d.cycle = s + doneRel;
        d.cnt   = expCnt;
        d.err   = err;
        d.cfg   = {bias, bound, step, relu, mp};
        doneQ.push_back(d);

        ptr = 0;
        for (int tt = 1; tt <= endRel; tt++) begin
            @(posedge clk); #1;
            start = secondStart && (tt == 5);
            if (secondStart && tt == 5) begin
                cfg_n_win = AW'(3);
                cfg_bias  = ~bias;
                cfg_bound = ~bound;
                cfg_relu  = ~relu;
                cfg_mp    = ~mp;
            end
            while (ptr < n && readCycles[ptr] < tt) ptr++;
            pause       = (tt <= pauseSeq.size()) ? pauseSeq[tt-1] : 1'($urandom_range(0, 1));
            core_out_en = pulseMap[tt];
            expBusy     = (n > 0) && (tt < doneRel);
            expStream   = (n > 0) && (tt <= c);
            expIdx      = ptr;
        end

        // Idle tail with stray result strobes that must not be counted.
        @(posedge clk); #1;
        start       = 1'b0;
        core_out_en = 1'b0;
        expBusy     = 1'b0;
        expStream   = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            core_out_en = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        core_out_en = 1'b0;
        checkOutput("all_reads_seen", addrQ.size(), 0);
        checkOutput("done_seen", doneQ.size(), 0);
        checkOutput("idle_out_cnt_hold", int'(out_cnt), expCnt);
        checkOutput("idle_err_to_hold", int'(err_to), int'(err));
        addrQ.delete();
        doneQ.delete();
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_rd_en_busy_done_err"},
                    int'({win_rd, core_en, busy, done, err_to}), 0);
        checkOutput({name, "_addr"}, int'(win_addr), 0);
        checkOutput({name, "_out_cnt"}, int'(out_cnt), 0);
        checkOutput({name, "_core_cfg"},
                    int'({core_bias, core_bound, core_step, core_relu, core_mp}), 0);
    endtask

    // Starts a 64-window layer and pulls reset while address 20 is pending.
    task automatic applyResetAbort();
        int     s;
        rdExp_t r;
        @(posedge clk); #1;
        s         = cyc;
        start     = 1'b1;
        cfg_n_win = AW'(64);
        cfg_bias  = 16'hBEEF;
        cfg_bound = 3'd5;
        cfg_step  = 3'd3;
        cfg_relu  = 1'b1;
        cfg_mp    = 1'b1;
        pause     = 1'b0;
        for (int j = 0; j < 20; j++) begin
            r.addr  = j;
            r.cycle = s + 1 + j;
            addrQ.push_back(r);
        end
        for (int tt = 1; tt <= 20; tt++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            expBusy   = 1'b1;
            expStream = 1'b1;
            expIdx    = tt - 1;
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        expBusy   = 1'b0;
        expStream = 1'b0;
        #1;
        checkAllZero("async_reset");
        checkOutput("abort_reads_seen", addrQ.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_reset_idle", int'({win_rd, busy, done}), 0);
        addrQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, k;
        reset       = 1'b0;
        start       = 1'b0;
        cfg_n_win   = '0;
        cfg_bias    = '0;
        cfg_bound   = '0;
        cfg_step    = '0;
        cfg_relu    = 1'b0;
        cfg_mp      = 1'b0;
        pause       = 1'b0;
        core_out_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;
        monOn = 1'b1;

        $display("[TB] full layer, no pooling, 4-cycle loopback");
        applyStimulus(64, 1'b0, 1'b1, 16'h0000, 3'd2, 3'd1, 64, 4, 0, 1'b0, 1'b0);
        $display("[TB] pooled layer with 16 results");
        applyStimulus(64, 1'b1, 1'b0, 16'h1234, 3'd3, 3'd2, 16, 4, 0, 1'b0, 1'b0);
        $display("[TB] pause held over stream cycles 10..14");
        applyStimulus(64, 1'b0, 1'b0, 16'h00A5, 3'd1, 3'd1, 64, 3, 0, 1'b1, 1'b0);
        $display("[TB] drain timeout with 5 of 8 results");
        applyStimulus(8, 1'b0, 1'b1, 16'h7FFF, 3'd7, 3'd4, 5, 2, 0, 1'b0, 1'b0);
        $display("[TB] reset during stream, then short layer");
        applyResetAbort();
        applyStimulus(4, 1'b0, 1'b0, 16'h0F0F, 3'd6, 3'd5, 4, 1, 0, 1'b0, 1'b0);
        $display("[TB] second start during stream, then empty layer");
        applyStimulus(20, 1'b0, 1'b1, 16'hC001, 3'd4, 3'd2, 20, 3, 0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 16'h5555, 3'd1, 3'd7, 0, 1, 0, 1'b0, 1'b0);
        $display("[TB] pooled layer with fewer than four windows");
        applyStimulus(3, 1'b1, 1'b0, 16'h0102, 3'd2, 3'd3, 0, 2, 0, 1'b0, 1'b0);
        $display("[TB] saturation: every window returns a result under pooling");
        applyStimulus(32, 1'b1, 1'b0, 16'h4321, 3'd5, 3'd6, 32, 5, 20, 1'b0, 1'b0);

        $display("[TB] randomized layers");
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(1, 40));
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : n;
            applyStimulus(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom), 3'($urandom), 3'($urandom), k,
                          int'($urandom_range(1, 6)), int'($urandom_range(0, 40)),
                          1'b0, 1'b0);
        end

        monOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ac_layer_ctrl.md
AC_LAYER_CTRL -- requirements
Module: ac_layer_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16: window-address and count width.
REQ-002 SHALL have parameter DRAIN_TO, default 64: maximum number of cycles the DRAIN state waits for outstanding outputs.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle layer start; ignored unless the FSM is in IDLE.
REQ-006 SHALL have port cfg_n_win, input, AW: number of 3x3 windows in the layer.
REQ-007 SHALL have ports cfg_bias (16), cfg_bound (3), cfg_step (3), cfg_relu (1), cfg_mp (1), all inputs: layer configuration, sampled on an accepted start.
REQ-008 SHALL have port pause, input, 1: while high, no new window is issued.
REQ-009 SHALL have ports win_rd, output, 1, and win_addr, output, AW: window-buffer read request; read data is valid 1 cycle later.
REQ-010 SHALL have port core_en, output, 1: arithmetic core input-valid; it is win_rd delayed by exactly one cycle.
REQ-011 SHALL have ports core_bias (16), core_bound (3), core_step (3), core_relu (1), core_mp (1), all outputs: registered copies of the latched configuration.
REQ-012 SHALL have port core_out_en, input, 1: output-valid from the arithmetic core.
REQ-013 SHALL have ports busy (1), done (1), err_to (1) and out_cnt (AW), all outputs: status and count of received outputs.

Function
REQ-014 SHALL implement the FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-015 In IDLE, a start that is high SHALL latch the configuration, clear the address and counters, and move the FSM to STREAM.
REQ-016 If start is accepted with cfg_n_win = 0, the FSM SHALL go directly to DONE and issue no reads.
REQ-017 In STREAM, each cycle with pause low SHALL set win_rd=1 with win_addr = issue index, and SHALL increment the index.
REQ-018 Issue SHALL be gap-free when pause is low, and pause high SHALL hold the index and give win_rd=0.
REQ-019 After issuing index cfg_n_win-1, the FSM SHALL move to DRAIN.
REQ-020 The expected output count SHALL be cfg_n_win when cfg_mp=0, and floor(cfg_n_win/4) when cfg_mp=1 (2x2 pooling).
REQ-021 out_cnt SHALL increment by 1 on every cycle with core_out_en=1 while busy, including during STREAM, and SHALL saturate at the expected count.
REQ-022 In DRAIN, reaching the expected count SHALL move the FSM to DONE.
REQ-023 In DRAIN, after DRAIN_TO cycles without reaching the expected count, the FSM SHALL set err_to=1 and move to DONE.
REQ-024 done SHALL be a 1-cycle pulse in DONE, after which the FSM returns to IDLE.
REQ-025 err_to SHALL be held until the next accepted start.
REQ-026 busy SHALL be 1 in STREAM and DRAIN, and 0 otherwise.
REQ-027 A start received while not in IDLE SHALL be ignored, with no effect on the configuration or counters.
REQ-028 core_out_en pulses received in IDLE SHALL be ignored.
REQ-029 The core_* configuration outputs SHALL remain stable from an accepted start until the next accepted start.

Reset
REQ-030 On reset low, all outputs SHALL go to 0 and the FSM to IDLE immediately (asynchronously).
REQ-031 A reset mid-operation SHALL abandon the layer with no done pulse.
REQ-032 After reset release, the block SHALL require a new start before issuing any read.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, STREAM=1, DRAIN=2, DONE=3), the AW default and the DRAIN_TO default.
REQ-034 One sub-module, ac_out_counter, SHALL implement the expected-count computation, the saturating out_cnt and the drain timeout.
REQ-035 The issue counter, the FSM and the en delay register SHALL stay in ac_layer_ctrl.

Verification
REQ-036 Scenario: start with n_win=64, mp=0, relu=1, bias=0, and core_out_en looped back with 4-cycle latency -> win_rd for 64 consecutive cycles with addresses 0..63; core_en lagging win_rd by 1 cycle; out_cnt=64; done pulses once; err_to=0.
REQ-037 Scenario: n_win=64, mp=1, with 16 core_out_en pulses -> done after the 16th pulse; out_cnt=16.
REQ-038 Scenario: pause held high for cycles 10..14 of STREAM -> win_addr holds 10 during the pause; no address is skipped or repeated; total of 64 reads.
REQ-039 Scenario: n_win=8 with only 5 core_out_en pulses -> err_to=1 after DRAIN_TO=64 drain cycles; done pulses; out_cnt=5.
REQ-040 Scenario: reset low at issue index 20 -> all outputs 0 immediately; no done pulse; a new start with n_win=4 runs cleanly from address 0.
REQ-041 Scenario: a second start during STREAM, and a start with n_win=0 -> the second start is ignored; the n_win=0 start produces done on the next cycle with zero reads.
